// File: rtl/bist_response_checker.sv
// BIST response checker: compacts valid ALU responses into an 8-bit MISR and
// reports pass/fail against a golden signature through a start/done handshake.
module bist_response_checker #(
  parameter int          NUM_PATTERNS = 16,
  parameter logic [7:0]  SEED         = 8'h00,
  parameter logic [7:0]  GOLDEN       = 8'hA5,
  parameter int          TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        resp_valid,
  input  logic [7:0]  OUT,
  input  logic        ZERO,
  output logic        busy,
  output logic        done,
  output logic        FAULT_DETECTED,
  output logic        timeout,
  output logic [7:0]  signature,
  output logic [15:0] resp_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int                IDLE_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT);
  localparam logic [15:0]       COUNT_LIMIT = 16'(NUM_PATTERNS);

  logic [1:0]        state_q, state_d;
  logic [7:0]        sig_q, sig_d;
  logic [15:0]       count_q, count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              fault_q, fault_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [7:0] misr_step(input logic [7:0] sig,
                                           input logic [7:0] data,
                                           input logic       zero);
    logic fb;
    fb = sig[7] ^ sig[5] ^ sig[4] ^ sig[3];
    return {sig[6:0], fb} ^ (data ^ {7'b0, zero});
  endfunction

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    count_d   = count_q;
    idle_d    = idle_q;
    fault_d   = fault_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_COLLECT;
          sig_d     = SEED;
          count_d   = 16'd0;
          idle_d    = '0;
          fault_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (resp_valid) begin
          sig_d   = misr_step(sig_q, OUT, ZERO);
          count_d = count_q + 16'd1;
          idle_d  = '0;
          if (count_q + 16'd1 == COUNT_LIMIT) begin
            state_d = ST_COMPARE;
          end
        end else begin
          idle_d = idle_q + IDLE_W'(1);
          // Abort leaves the signature frozen at whatever was compacted so far.
          if (idle_q + IDLE_W'(1) == IDLE_LIMIT) begin
            state_d   = ST_DONE;
            fault_d   = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      ST_COMPARE: begin
        fault_d = (sig_q != GOLDEN);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_COLLECT) || (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sig_q     <= SEED;
      count_q   <= 16'd0;
      idle_q    <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign FAULT_DETECTED = fault_q;
  assign timeout        = timeout_q;
  assign signature      = sig_q;
  assign resp_count     = count_q;

endmodule

// File: tb/tb_bist_response_checker.sv
// Bench for bist_response_checker: three differently parameterised checkers share
// one stimulus stream and are compared every cycle against a run-level model.
module tb_bist_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       resp_valid;
  logic [7:0] out_i;
  logic       zero_i;

  logic        busy_w  [3];
  logic        done_w  [3];
  logic        fault_w [3];
  logic        to_w    [3];
  logic [7:0]  sig_w   [3];
  logic [15:0] cnt_w   [3];

  bist_response_checker #(.NUM_PATTERNS(2), .SEED(8'h00), .GOLDEN(8'hB5), .TIMEOUT(4)) u0 (
    .clk(clk), .reset(reset), .start(start), .resp_valid(resp_valid), .OUT(out_i), .ZERO(zero_i),
    .busy(busy_w[0]), .done(done_w[0]), .FAULT_DETECTED(fault_w[0]), .timeout(to_w[0]),
    .signature(sig_w[0]), .resp_count(cnt_w[0]));

  bist_response_checker #(.NUM_PATTERNS(1), .SEED(8'h00), .GOLDEN(8'h5A), .TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset), .start(start), .resp_valid(resp_valid), .OUT(out_i), .ZERO(zero_i),
    .busy(busy_w[1]), .done(done_w[1]), .FAULT_DETECTED(fault_w[1]), .timeout(to_w[1]),
    .signature(sig_w[1]), .resp_count(cnt_w[1]));

  bist_response_checker #(.NUM_PATTERNS(16), .SEED(8'h3C), .GOLDEN(8'hA5), .TIMEOUT(4)) u2 (
    .clk(clk), .reset(reset), .start(start), .resp_valid(resp_valid), .OUT(out_i), .ZERO(zero_i),
    .busy(busy_w[2]), .done(done_w[2]), .FAULT_DETECTED(fault_w[2]), .timeout(to_w[2]),
    .signature(sig_w[2]), .resp_count(cnt_w[2]));

  int         np_c   [3] = '{2, 1, 16};
  int         to_c   [3] = '{4, 4, 4};
  logic [7:0] seed_c [3] = '{8'h00, 8'h00, 8'h3C};
  logic [7:0] gold_c [3] = '{8'hB5, 8'h5A, 8'hA5};

  // Model: a run is either collecting, or counting down a fixed number of cycles to its done pulse.
  bit         m_col   [3];
  int         m_din   [3];
  logic [7:0] m_sig   [3];
  int         m_cnt   [3];
  int         m_idle  [3];
  bit         m_fault [3];
  bit         m_to    [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic logic [7:0] refMisr(input logic [7:0] s, input logic [7:0] o, input logic z);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ o ^ {7'b0, z};
  endfunction

  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_col[k] = 1'b0; m_din[k] = 0; m_sig[k] = seed_c[k]; m_cnt[k] = 0;
        m_idle[k] = 0; m_fault[k] = 1'b0; m_to[k] = 1'b0;
      end else if (m_din[k] > 0) begin
        if (m_din[k] == 2) m_fault[k] = (m_sig[k] != gold_c[k]);
        m_din[k] = m_din[k] - 1;
      end else if (m_col[k]) begin
        if (resp_valid) begin
          m_sig[k] = refMisr(m_sig[k], out_i, zero_i);
          m_cnt[k] = m_cnt[k] + 1;
          m_idle[k] = 0;
          if (m_cnt[k] == np_c[k]) begin
            m_col[k] = 1'b0;
            m_din[k] = 2;
          end
        end else begin
          m_idle[k] = m_idle[k] + 1;
          if (m_idle[k] == to_c[k]) begin
            m_col[k] = 1'b0; m_din[k] = 1; m_fault[k] = 1'b1; m_to[k] = 1'b1;
          end
        end
      end else if (start) begin
        m_col[k] = 1'b1; m_sig[k] = seed_c[k]; m_cnt[k] = 0;
        m_idle[k] = 0; m_fault[k] = 1'b0; m_to[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] o, input logic z);
    start = st; resp_valid = v; out_i = o; zero_i = z;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("u%0d.busy", k), 16'(busy_w[k]), 16'(m_col[k] || (m_din[k] == 2)));
          checkOutput($sformatf("u%0d.done", k), 16'(done_w[k]), 16'(m_din[k] == 1));
          checkOutput($sformatf("u%0d.fault", k), 16'(fault_w[k]), 16'(m_fault[k]));
          checkOutput($sformatf("u%0d.timeout", k), 16'(to_w[k]), 16'(m_to[k]));
          checkOutput($sformatf("u%0d.signature", k), 16'(sig_w[k]), 16'(m_sig[k]));
          checkOutput($sformatf("u%0d.resp_count", k), cnt_w[k], 16'(m_cnt[k]));
        end
      end
    end
  end

  initial begin
    int seg_valid_pct;
    reset = 1'b1; start = 1'b0; resp_valid = 1'b0; out_i = 8'h00; zero_i = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    checkOutput("rst.signature", 16'(sig_w[0]), 16'h0000);
    checkOutput("rst.busy", 16'(busy_w[0]), 16'h0000);

    $display("[TB] basic runs");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("start.busy", 16'(busy_w[0]), 16'h0001);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
    checkOutput("u1.sig_after_r1", 16'(sig_w[1]), 16'h005A);
    checkOutput("u1.done_compare_cycle", 16'(done_w[1]), 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("u1.done_latency", 16'(done_w[1]), 16'h0001);
    checkOutput("u1.fault_pass", 16'(fault_w[1]), 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    checkOutput("u0.done_latency", 16'(done_w[0]), 16'h0001);
    checkOutput("u0.sig_pass", 16'(sig_w[0]), 16'h00B5);
    checkOutput("model.sig_pass", 16'(m_sig[0]), 16'h00B5);
    checkOutput("u0.fault_pass", 16'(fault_w[0]), 16'h0000);
    checkOutput("u0.count_pass", cnt_w[0], 16'd2);
    checkOutput("u2.count_three", cnt_w[2], 16'd3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("u2.done_early", 16'(done_w[2]), 16'h0000);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("u2.done_timeout", 16'(done_w[2]), 16'h0001);
    checkOutput("u2.timeout_flag", 16'(to_w[2]), 16'h0001);
    checkOutput("u2.fault_timeout", 16'(fault_w[2]), 16'h0001);
    checkOutput("u2.count_timeout", cnt_w[2], 16'd3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] failing rerun with ignored starts");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("u0.done_fail", 16'(done_w[0]), 16'h0001);
    checkOutput("u0.sig_fail", 16'(sig_w[0]), 16'h00B4);
    checkOutput("model.sig_fail", 16'(m_sig[0]), 16'h00B4);
    checkOutput("u0.fault_fail", 16'(fault_w[0]), 16'h0001);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("u0.start_in_done", 16'(busy_w[0]), 16'h0000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] responses past the pattern count");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'($urandom));
    checkOutput("u0.count_saturate", cnt_w[0], 16'd2);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    checkOutput("rst_mid.busy", 16'(busy_w[0]), 16'h0000);
    checkOutput("rst_mid.signature", 16'(sig_w[2]), 16'h003C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_mid.no_done", 16'(done_w[0]), 16'h0000);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rerun.done", 16'(done_w[0]), 16'h0001);
    checkOutput("rerun.fault", 16'(fault_w[0]), 16'h0000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] randomized traffic");
    seg_valid_pct = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) seg_valid_pct = $urandom_range(10, 100);
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus(1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(1, 100) <= seg_valid_pct),
                    8'($urandom), 1'($urandom));
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
